// File: rtl/keypad_bcd_scanner_if.sv
// Digit handshake between the keypad scanner (master) and the downstream BCD
// digit consumer (slave).
interface keypad_bcd_scanner_if;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ready;

    modport master (
        output code,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/keypad_bcd_scanner.sv
// Synchronises and debounces ten decimal key lines and emits one BCD digit
// per clean single-key press; multi-key presses raise a one-cycle error.
//
// state        | meaning
// IDLE         | no key seen on the synchronised lines
// DEBOUNCE     | key pattern captured in snap, counting stable cycles
// EMIT         | code presented, waiting for code_ready
// WAIT_RELEASE | waiting for all keys released and stable
module keypad_bcd_scanner #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            keys,
    keypad_bcd_scanner_if.master  bus,
    output logic                  multi_err,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [9:0]       s1, ks;
    logic [9:0]       snap, snap_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       code_q, code_n;
    logic             valid_q, valid_n;
    logic             multi_q, multi_n;
    logic [3:0]       snap_idx;
    logic             snap_one_hot;

    // snap is never zero while it is inspected, so clearing the lowest set
    // bit leaving zero means exactly one bit is set.
    assign snap_one_hot = ((snap & (snap - 10'd1)) == 10'd0);

    always_comb begin
        snap_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (snap[i]) begin
                snap_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            ks      <= '0;
            state   <= IDLE;
            snap    <= '0;
            cnt     <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            s1      <= keys;
            ks      <= s1;
            state   <= state_n;
            snap    <= snap_n;
            cnt     <= cnt_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            multi_q <= multi_n;
        end
    end

    always_comb begin
        state_n = state;
        snap_n  = snap;
        cnt_n   = cnt;
        code_n  = code_q;
        valid_n = valid_q;
        multi_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (ks != 10'd0) begin
                    snap_n  = ks;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks == 10'd0) begin
                    state_n = IDLE;
                end else if (ks != snap) begin
                    snap_n = ks;
                    cnt_n  = '0;
                end else if (cnt != DB_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else if (snap_one_hot) begin
                    code_n  = snap_idx;
                    valid_n = 1'b1;
                    state_n = EMIT;
                end else begin
                    multi_n = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT_RELEASE;
                end
            end
            EMIT: begin
                if (bus.code_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (ks != 10'd0) begin
                    cnt_n = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.code       = code_q;
    assign bus.code_valid = valid_q;
    assign multi_err      = multi_q;
    assign busy           = (state != IDLE);
endmodule

// File: doc/keypad_bcd_scanner.md
Name: keypad_bcd_scanner

Overview:
- Sequencing controller in front of the 10-line decimal-to-BCD encoder stage.
- Synchronises and debounces 10 raw decimal key lines, and rejects multi-key presses with an error pulse.
- Emits exactly one 4-bit BCD code per valid key press, over a valid/ready handshake to the downstream digit consumer.
- Blocks repeat codes until all keys are released and debounced.

Parameters:
- DB_CYCLES, default 16, number of consecutive stable clocks needed to accept a press or a release. Legal range 1..65535.
- CNT_W, default 16, debounce counter width. Must hold DB_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- keys  input  10  raw key lines; keys[i]=1 means decimal digit i is pressed; asynchronous to clk.
- code_ready  input  1  downstream accepts code when high.
- code  output  4  BCD digit 0..9; valid only while code_valid=1.
- code_valid  output  1  code is held stable until accepted.
- multi_err  output  1  one-cycle pulse: a debounced press had more than one key set.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: rst is sampled on the clk rising edge (synchronous, active-high).
  - Forces state=IDLE, code=0, code_valid=0, multi_err=0, busy=0.
  - Clears the debounce counter, the snapshot register and both synchroniser stages.
  - Reset mid-operation discards any pending code without a handshake.
- Synchroniser: 2-flop chain keys -> s1 -> ks. All decisions use ks only.
- Snapshot register snap[9:0] and counter cnt[CNT_W-1:0].
- FSM states: IDLE, DEBOUNCE, EMIT, WAIT_RELEASE.
  - IDLE: if ks!=0, then snap<=ks, cnt<=0, go to DEBOUNCE.
  - DEBOUNCE:
    - ks==0: back to IDLE (glitch rejected).
    - ks!=0 and ks!=snap: snap<=ks, cnt<=0, stay in DEBOUNCE.
    - ks==snap and cnt<DB_CYCLES-1: cnt<=cnt+1.
    - ks==snap and cnt==DB_CYCLES-1, snap one-hot: code<=index of set bit (bit i -> i), code_valid<=1, go to EMIT.
    - ks==snap and cnt==DB_CYCLES-1, snap has 2 or more bits set: multi_err<=1 for exactly one cycle, no code, cnt<=0, go to WAIT_RELEASE.
  - EMIT:
    - code and code_valid hold until a cycle with code_valid & code_ready.
    - On that edge: code_valid<=0, cnt<=0, go to WAIT_RELEASE.
    - Key changes or release during EMIT are ignored; the code is never withdrawn.
  - WAIT_RELEASE:
    - ks!=0: cnt<=0.
    - ks==0: cnt<=cnt+1.
    - When ks==0 and cnt==DB_CYCLES-1: go to IDLE.
    - A new press during release debounce restarts the count; it never produces a code.
- Latency:
  - Clean one-hot press stable from the edge before edge 1: code_valid rises after edge DB_CYCLES+3.
  - With code_ready held high, code_valid lasts exactly 1 cycle.
- code_ready while code_valid=0 has no effect.
- code is registered; it keeps its last value after acceptance and returns to 0 only on reset.
- At most one code or one multi_err per press/release cycle.
- multi_err and code_valid are never high in the same cycle.

Test Plan:
- Reset then one-hot press (DB_CYCLES=4, code_ready=1): rst=1 for 2 clocks, then keys=10'b0000001000 held → code_valid=1 for 1 cycle after edge 7 with code=4'd3. Hold keys for 50 clocks → no second code. Release, wait 10 clocks → busy=0.
- Sweep all keys in the 10-line encoder pattern: keys=10'b1000000000 down to 10'b0000000001, each held 500 clocks, 20 clocks of 0 between → codes 9,8,...,0 emitted in order, once each, multi_err never 1.
- Bounce rejection (DB_CYCLES=4): keys=10'b0000000100 for 3 clocks, 0 for 1 clock, repeated 5 times, then held 20 clocks → exactly one code=4'd2, emitted after the final stable run.
- Multi-key (DB_CYCLES=4): keys=10'b0000100001 held → multi_err=1 for exactly 1 cycle, code_valid stays 0. After release and 4+ clean zero clocks, keys=10'b0000100000 → code=4'd5.
- Backpressure: code_ready=0, keys=10'b0010000000 → code_valid=1 with code=4'd7, stable while the key is released and keys=10'b0000000010 is pressed. Assert code_ready after 30 clocks → one transfer; the held key 1 produces no code until released and re-pressed.
- Reset mid-EMIT: code_valid=1 with code=4'd7, rst=1 for 1 clock → next cycle code_valid=0, code=0, busy=0, no transfer counted.
